// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data; issue is combinational, responses are registered (1 cycle).
// A rejected requester (mem2proc_response==0) sees ready=0 and must hold; no retry state is kept here.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req_valid,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_req_ready,
  input  logic            dm_req_valid,
  input  logic            dm_req_store,
  input  logic [XLEN-1:0] dm_req_addr,
  input  logic [63:0]     dm_req_data,
  output logic            dm_req_ready,
  input  logic            flush,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic            if_resp_valid,
  output logic [63:0]     if_resp_data,
  output logic            dm_resp_valid,
  output logic [63:0]     dm_resp_data,
  output logic            tag_err
);

  localparam int TAG_W = 4;
  localparam int NT    = 1 << TAG_W;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [TAG_W-1:0] MAX_TAG = TAG_W'(NUM_TAGS);
  localparam logic [SW-1:0]    SLIMIT  = SW'(STARVE_LIMIT);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef struct packed {
    logic valid;
    logic owner;
    logic stale;
  } tag_ent_t;

  tag_ent_t      tbl [NT];
  tag_ent_t      rsp_ent;
  logic [SW-1:0] streak;
  logic          grant_if, grant_dm, accepted, alloc;
  logic          rsp_hit, rsp_untracked, if_deliver, dm_deliver;
  bus_cmd_e      cmd;

  always_comb begin
    grant_dm         = 1'b0;
    grant_if         = 1'b0;
    cmd              = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (!reset) begin
      // data normally wins; fetch takes over once it has lost STARVE_LIMIT times in a row
      grant_dm = dm_req_valid && (!if_req_valid || streak != SLIMIT);
      grant_if = if_req_valid && !grant_dm;
    end
    accepted     = (mem2proc_response != '0);
    if_req_ready = grant_if && accepted;
    dm_req_ready = grant_dm && accepted;
    if (grant_dm) begin
      cmd           = dm_req_store ? BUS_STORE : BUS_LOAD;
      proc2mem_addr = dm_req_addr;
      proc2mem_data = dm_req_store ? dm_req_data : 64'd0;
    end else if (grant_if) begin
      cmd           = BUS_LOAD;
      proc2mem_addr = if_req_addr;
    end
    proc2mem_command = cmd;
    alloc = (if_req_ready || (dm_req_ready && !dm_req_store)) && (mem2proc_response <= MAX_TAG);
  end

  always_comb begin
    rsp_ent       = tbl[mem2proc_tag];
    rsp_hit       = (mem2proc_tag != '0) && (mem2proc_tag <= MAX_TAG) && rsp_ent.valid;
    rsp_untracked = (mem2proc_tag != '0) && !rsp_hit;
    if_deliver    = rsp_hit && (rsp_ent.owner == OWN_IF) && !rsp_ent.stale && !flush;
    dm_deliver    = rsp_hit && (rsp_ent.owner == OWN_DM);
  end

  // Per-entry order: retire the returning tag, squash live fetches, then allocate (allocate wins).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NT; t++) tbl[t] <= '0;
    end else begin
      for (int t = 1; t < NT; t++) begin
        if (rsp_hit && mem2proc_tag == TAG_W'(t))
          tbl[t].valid <= 1'b0;
        else if (flush && tbl[t].valid && tbl[t].owner == OWN_IF)
          tbl[t].stale <= 1'b1;
        if (alloc && mem2proc_response == TAG_W'(t))
          tbl[t] <= '{valid: 1'b1, owner: grant_dm, stale: 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      streak <= '0;
    else if (!if_req_valid || if_req_ready)
      streak <= '0;
    else if (dm_req_ready && streak != SLIMIT)
      streak <= streak + SW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      dm_resp_valid <= 1'b0;
      dm_resp_data  <= '0;
      tag_err       <= 1'b0;
    end else begin
      if_resp_valid <= if_deliver;
      dm_resp_valid <= dm_deliver;
      if (if_deliver) if_resp_data <= mem2proc_data;
      if (dm_deliver) dm_resp_data <= mem2proc_data;
      if (rsp_untracked) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int XLEN = 32;
  localparam int NUM_TAGS = 15;
  localparam int STARVE_LIMIT = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            if_req_valid;
  logic [XLEN-1:0] if_req_addr;
  logic            if_req_ready;
  logic            dm_req_valid;
  logic            dm_req_store;
  logic [XLEN-1:0] dm_req_addr;
  logic [63:0]     dm_req_data;
  logic            dm_req_ready;
  logic            flush;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic            if_resp_valid;
  logic [63:0]     if_resp_data;
  logic            dm_resp_valid;
  logic [63:0]     dm_resp_data;
  logic            tag_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.XLEN(XLEN), .NUM_TAGS(NUM_TAGS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .dm_req_valid(dm_req_valid), .dm_req_store(dm_req_store), .dm_req_addr(dm_req_addr),
    .dm_req_data(dm_req_data), .dm_req_ready(dm_req_ready), .flush(flush),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data), .tag_err(tag_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_req_addr = '0;
    dm_req_valid = 1'b0; dm_req_store = 1'b0; dm_req_addr = '0; dm_req_data = '0;
    flush = 1'b0; mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h40;
    dm_req_valid = 1'b1; dm_req_addr = 32'h80; mem2proc_response = 4'd5;
    #2;
    n_chk++; if (proc2mem_command !== 2'd0) begin n_fail++; $display("FAIL reset_cmd: got %0d expected 0", proc2mem_command); end
    n_chk++; if (if_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready: got %b expected 0", if_req_ready); end
    n_chk++; if (dm_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dm_ready: got %b expected 0", dm_req_ready); end
    n_chk++; if ({if_resp_valid, dm_resp_valid, tag_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {if_resp_valid, dm_resp_valid, tag_err}); end
    n_chk++; if ({if_resp_data, dm_resp_data} !== 128'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {if_resp_data, dm_resp_data}); end
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_fetch_only();
    do_reset();
    if_req_valid = 1'b1; if_req_addr = 32'h100; mem2proc_response = 4'd3;
    #2;
    n_chk++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready: got %b expected 1", if_req_ready); end
    n_chk++; if (dm_req_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_dm_ready: got %b expected 0", dm_req_ready); end
    n_chk++; if (proc2mem_command !== 2'd1) begin n_fail++; $display("FAIL fetch_cmd: got %0d expected 1", proc2mem_command); end
    n_chk++; if (proc2mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_addr: got %h expected 100", proc2mem_addr); end
    tick();
    idle_inputs();
    tick();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    n_chk++; if (if_resp_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_resp_valid: got %b expected 1", if_resp_valid); end
    n_chk++; if (if_resp_data !== 64'hAAAA_BBBB_CCCC_DDDD) begin n_fail++; $display("FAIL fetch_resp_data: got %h expected aaaabbbbccccdddd", if_resp_data); end
    n_chk++; if (dm_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_dm_resp: got %b expected 0", dm_resp_valid); end
    idle_inputs();
    tick();
    n_chk++; if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: got %b expected 0", if_resp_valid); end
    n_chk++; if (if_resp_data !== 64'hAAAA_BBBB_CCCC_DDDD) begin n_fail++; $display("FAIL fetch_hold: got %h expected aaaabbbbccccdddd", if_resp_data); end
  endtask

  task automatic test_starvation();
    bit exp_if, rej;
    do_reset();
    if_req_valid = 1'b1; if_req_addr = 32'h200;
    dm_req_valid = 1'b1; dm_req_store = 1'b1; dm_req_addr = 32'h300; dm_req_data = 64'h55;
    for (int i = 0; i < 18; i++) begin
      exp_if = (i == 4) || (i == 9) || (i == 17);
      rej = (i >= 10) && (i <= 12);
      mem2proc_response = rej ? 4'd0 : 4'd1;
      #2;
      n_chk++; if (proc2mem_command !== (exp_if ? 2'd1 : 2'd2)) begin n_fail++; $display("FAIL starve_cmd[%0d]: got %0d expected %0d", i, proc2mem_command, exp_if ? 1 : 2); end
      n_chk++; if (if_req_ready !== (exp_if && !rej)) begin n_fail++; $display("FAIL starve_if_ready[%0d]: got %b expected %b", i, if_req_ready, exp_if && !rej); end
      n_chk++; if (dm_req_ready !== (!exp_if && !rej)) begin n_fail++; $display("FAIL starve_dm_ready[%0d]: got %b expected %b", i, dm_req_ready, !exp_if && !rej); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    if_req_valid = 1'b1; if_req_addr = 32'h400; mem2proc_response = 4'd5;
    #2;
    n_chk++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_first_ready: got %b expected 1", if_req_ready); end
    tick();
    idle_inputs(); flush = 1'b1;
    tick();
    idle_inputs(); mem2proc_tag = 4'd5; mem2proc_data = 64'h1111;
    tick();
    n_chk++; if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b expected 0", if_resp_valid); end
    n_chk++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL flush_no_err: got %b expected 0", tag_err); end
    idle_inputs();
    if_req_valid = 1'b1; if_req_addr = 32'h408; mem2proc_response = 4'd5; flush = 1'b1;
    #2;
    n_chk++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_refetch_ready: got %b expected 1", if_req_ready); end
    tick();
    idle_inputs(); mem2proc_tag = 4'd5; mem2proc_data = 64'h2222_3333;
    tick();
    n_chk++; if (if_resp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_refetch_valid: got %b expected 1", if_resp_valid); end
    n_chk++; if (if_resp_data !== 64'h2222_3333) begin n_fail++; $display("FAIL flush_refetch_data: got %h expected 22223333", if_resp_data); end
    tick();
    n_chk++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL flush_entry_freed: got %b expected 1", tag_err); end
    idle_inputs();
  endtask

  task automatic test_store_tag_err();
    do_reset();
    dm_req_valid = 1'b1; dm_req_store = 1'b1; dm_req_addr = 32'h800;
    dm_req_data = 64'h1234_5678_9ABC_DEF0; mem2proc_response = 4'd2;
    #2;
    n_chk++; if (dm_req_ready !== 1'b1) begin n_fail++; $display("FAIL store_ready: got %b expected 1", dm_req_ready); end
    n_chk++; if (proc2mem_command !== 2'd2) begin n_fail++; $display("FAIL store_cmd: got %0d expected 2", proc2mem_command); end
    n_chk++; if (proc2mem_data !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL store_data: got %h expected 123456789abcdef0", proc2mem_data); end
    tick();
    idle_inputs(); mem2proc_tag = 4'd2; mem2proc_data = 64'h99;
    tick();
    n_chk++; if ({if_resp_valid, dm_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL store_no_resp: got %b expected 00", {if_resp_valid, dm_resp_valid}); end
    n_chk++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL store_tag_err: got %b expected 1", tag_err); end
    idle_inputs();
    repeat (3) tick();
    n_chk++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL store_tag_err_sticky: got %b expected 1", tag_err); end
  endtask

  task automatic test_same_cycle_tag();
    do_reset();
    dm_req_valid = 1'b1; dm_req_addr = 32'h900; mem2proc_response = 4'd7;
    tick();
    dm_req_addr = 32'h908; mem2proc_tag = 4'd7; mem2proc_data = 64'hD1D1;
    #2;
    n_chk++; if (dm_req_ready !== 1'b1) begin n_fail++; $display("FAIL same_tag_ready: got %b expected 1", dm_req_ready); end
    tick();
    n_chk++; if (dm_resp_valid !== 1'b1 || dm_resp_data !== 64'hD1D1) begin n_fail++; $display("FAIL same_tag_first: got %b/%h expected 1/d1d1", dm_resp_valid, dm_resp_data); end
    idle_inputs(); mem2proc_tag = 4'd7; mem2proc_data = 64'hD2D2;
    tick();
    n_chk++; if (dm_resp_valid !== 1'b1 || dm_resp_data !== 64'hD2D2) begin n_fail++; $display("FAIL same_tag_second: got %b/%h expected 1/d2d2", dm_resp_valid, dm_resp_data); end
    n_chk++; if (tag_err !== 1'b0 || if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL same_tag_side: got err=%b ifv=%b expected 0/0", tag_err, if_resp_valid); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    if_req_valid = 1'b1; if_req_addr = 32'h100; mem2proc_response = 4'd1;
    tick();
    idle_inputs(); dm_req_valid = 1'b1; dm_req_addr = 32'h200; mem2proc_response = 4'd2;
    tick();
    dm_req_addr = 32'h208; mem2proc_response = 4'd3;
    tick();
    dm_req_addr = 32'h210; mem2proc_response = 4'd4; mem2proc_tag = 4'd2; mem2proc_data = 64'hBEEF;
    tick();
    n_chk++; if (dm_resp_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b expected 1", dm_resp_valid); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({dm_resp_valid, if_resp_valid, tag_err} !== 3'b000) begin n_fail++; $display("FAIL areset_flags: got %b expected 000", {dm_resp_valid, if_resp_valid, tag_err}); end
    n_chk++; if (dm_resp_data !== 64'd0) begin n_fail++; $display("FAIL areset_data: got %h expected 0", dm_resp_data); end
    n_chk++; if (proc2mem_command !== 2'd0 || dm_req_ready !== 1'b0) begin n_fail++; $display("FAIL areset_issue: got cmd=%0d rdy=%b expected 0/0", proc2mem_command, dm_req_ready); end
    @(negedge clock);
    reset = 1'b0;
    idle_inputs(); mem2proc_tag = 4'd1; mem2proc_data = 64'h77;
    tick();
    n_chk++; if (tag_err !== 1'b1 || if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL areset_old_tag: got err=%b ifv=%b expected 1/0", tag_err, if_resp_valid); end
    idle_inputs();
  endtask

  task automatic test_random();
    bit m_pend [16];
    bit m_dm   [16];
    bit m_sq   [16];
    int m_wait, t, r;
    bit m_err, e_if_v, e_dm_v, win_dm, win_if, acc;
    logic [63:0] e_if_d, e_dm_d, e_data;
    logic [31:0] e_addr;
    logic [1:0]  e_cmd;
    int live [$];
    do_reset();
    foreach (m_pend[i]) begin m_pend[i] = 0; m_dm[i] = 0; m_sq[i] = 0; end
    m_wait = 0; m_err = 0; e_if_d = '0; e_dm_d = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if_req_valid = ($urandom_range(0, 2) != 0);
      if_req_addr  = $urandom() & 32'hFFFF_FFF8;
      dm_req_valid = ($urandom_range(0, 2) != 0);
      dm_req_store = ($urandom_range(0, 2) == 0);
      dm_req_addr  = $urandom();
      dm_req_data  = {$urandom(), $urandom()};
      flush        = ($urandom_range(0, 7) == 0);
      mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, NUM_TAGS));
      mem2proc_data = {$urandom(), $urandom()};
      live.delete();
      for (int k = 1; k <= NUM_TAGS; k++) if (m_pend[k]) live.push_back(k);
      r = $urandom_range(0, 9);
      if (r < 5 && live.size() > 0) mem2proc_tag = 4'(live[$urandom_range(0, live.size() - 1)]);
      else if (r == 5) mem2proc_tag = 4'($urandom_range(1, NUM_TAGS));
      else mem2proc_tag = 4'd0;

      // fetch is owed the port after STARVE_LIMIT consecutive data issues while it waited
      win_dm = dm_req_valid && !(if_req_valid && m_wait >= STARVE_LIMIT);
      win_if = if_req_valid && !win_dm;
      acc = (mem2proc_response != 0);
      e_cmd  = win_dm ? (dm_req_store ? 2'd2 : 2'd1) : (win_if ? 2'd1 : 2'd0);
      e_addr = win_dm ? dm_req_addr : (win_if ? if_req_addr : 32'd0);
      e_data = (win_dm && dm_req_store) ? dm_req_data : 64'd0;
      #2;
      n_chk++; if (proc2mem_command !== e_cmd) begin n_fail++; $display("FAIL rnd_cmd[%0d]: got %0d expected %0d", cyc, proc2mem_command, e_cmd); end
      n_chk++; if (proc2mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", cyc, proc2mem_addr, e_addr); end
      n_chk++; if (proc2mem_data !== e_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", cyc, proc2mem_data, e_data); end
      n_chk++; if (if_req_ready !== (win_if && acc)) begin n_fail++; $display("FAIL rnd_if_ready[%0d]: got %b expected %b", cyc, if_req_ready, win_if && acc); end
      n_chk++; if (dm_req_ready !== (win_dm && acc)) begin n_fail++; $display("FAIL rnd_dm_ready[%0d]: got %b expected %b", cyc, dm_req_ready, win_dm && acc); end

      e_if_v = 0; e_dm_v = 0;
      t = int'(mem2proc_tag);
      if (t != 0) begin
        if (!m_pend[t]) m_err = 1;
        else begin
          if (m_dm[t]) begin e_dm_v = 1; e_dm_d = mem2proc_data; end
          else if (!m_sq[t] && !flush) begin e_if_v = 1; e_if_d = mem2proc_data; end
          m_pend[t] = 0;
        end
      end
      if (flush) for (int k = 1; k <= NUM_TAGS; k++) if (m_pend[k] && !m_dm[k]) m_sq[k] = 1;
      if (acc && (win_if || (win_dm && !dm_req_store))) begin
        t = int'(mem2proc_response);
        m_pend[t] = 1; m_dm[t] = win_dm; m_sq[t] = 0;
      end
      if (!if_req_valid || (win_if && acc)) m_wait = 0;
      else if (win_dm && acc && m_wait < STARVE_LIMIT) m_wait++;

      tick();
      n_chk++; if (if_resp_valid !== e_if_v) begin n_fail++; $display("FAIL rnd_if_valid[%0d]: got %b expected %b", cyc, if_resp_valid, e_if_v); end
      n_chk++; if (if_resp_data !== e_if_d) begin n_fail++; $display("FAIL rnd_if_data[%0d]: got %h expected %h", cyc, if_resp_data, e_if_d); end
      n_chk++; if (dm_resp_valid !== e_dm_v) begin n_fail++; $display("FAIL rnd_dm_valid[%0d]: got %b expected %b", cyc, dm_resp_valid, e_dm_v); end
      n_chk++; if (dm_resp_data !== e_dm_d) begin n_fail++; $display("FAIL rnd_dm_data[%0d]: got %h expected %h", cyc, dm_resp_data, e_dm_d); end
      n_chk++; if (tag_err !== m_err) begin n_fail++; $display("FAIL rnd_tag_err[%0d]: got %b expected %b", cyc, tag_err, m_err); end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_fetch_only();
    test_starvation();
    test_flush();
    test_store_tag_err();
    test_same_cycle_tag();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
